// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared widths, source count and FSM encoding for the 4:1 round-robin arbiter
package arbitro_pkg;
    localparam int DATA_W = 12;
    localparam int CNT_W  = 8;
    localparam int N_SRC  = 4;
    typedef enum logic [1:0] {ST_RESET = 2'd0, ST_IDLE = 2'd1, ST_ACTIVE = 2'd2} state_t;
endpackage

// File: rtl/arbitro_rr_sel.sv
// arbitro_rr_sel: combinational rotate-priority picker, search order ptr+1, ptr+2, ptr+3, ptr
// ports: ptr last-granted index, req request vector, gnt one-hot grant, gnt_idx granted index
module arbitro_rr_sel
    import arbitro_pkg::*;
(
    input  logic [1:0]       ptr,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] gnt,
    output logic [1:0]       gnt_idx
);
    logic w_any;
    // scan farthest-first so the nearest candidate after ptr overwrites and wins
    always_comb begin
        gnt_idx = ptr;
        w_any   = 1'b0;
        for (int k = N_SRC; k >= 1; k--) begin
            if (req[ptr + 2'(k)]) begin
                gnt_idx = ptr + 2'(k);
                w_any   = 1'b1;
            end
        end
    end
    assign gnt = w_any ? 4'b0001 << gnt_idx : '0;
endmodule

// File: rtl/arbitro_rr_4a1.sv
// arbitro_rr_4a1: 4-to-1 round-robin FIFO merger with per-source word counters
// ports: empty/fifo_out0..3 source FIFO heads, pop one-hot source pop, almost_full destination
//        backpressure, push/data_out registered destination write, grant last source popped,
//        idle FSM idle flag, cnt_sel/cnt_out combinational counter readback
module arbitro_rr_4a1 #(
    parameter int DATA_W = arbitro_pkg::DATA_W,
    parameter int CNT_W  = arbitro_pkg::CNT_W
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic [arbitro_pkg::N_SRC-1:0] empty,
    input  logic [DATA_W-1:0]             fifo_out0,
    input  logic [DATA_W-1:0]             fifo_out1,
    input  logic [DATA_W-1:0]             fifo_out2,
    input  logic [DATA_W-1:0]             fifo_out3,
    input  logic                          almost_full,
    output logic [arbitro_pkg::N_SRC-1:0] pop,
    output logic                          push,
    output logic [DATA_W-1:0]             data_out,
    output logic [1:0]                    grant,
    output logic                          idle,
    input  logic [1:0]                    cnt_sel,
    output logic [CNT_W-1:0]              cnt_out
);
    import arbitro_pkg::*;
    state_t            r_state, w_state_nxt;
    logic [1:0]        r_ptr, w_idx;
    logic [N_SRC-1:0]  w_req, w_gnt;
    logic              w_pop;
    logic [DATA_W-1:0] w_fifo [N_SRC];
    logic [CNT_W-1:0]  r_cnt  [N_SRC];

    assign w_fifo[0] = fifo_out0;
    assign w_fifo[1] = fifo_out1;
    assign w_fifo[2] = fifo_out2;
    assign w_fifo[3] = fifo_out3;

    // almost_full gates pops in the same cycle; one word may still be in flight
    assign w_req = (r_state != ST_RESET && !almost_full) ? ~empty : '0;

    arbitro_rr_sel u_sel (
        .ptr     (r_ptr),
        .req     (w_req),
        .gnt     (w_gnt),
        .gnt_idx (w_idx)
    );

    assign w_pop   = |w_gnt;
    assign pop     = w_gnt;
    assign grant   = r_ptr;
    assign idle    = r_state == ST_IDLE;
    assign cnt_out = r_cnt[cnt_sel];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) r_state <= ST_RESET;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_pop) w_state_nxt = ST_ACTIVE;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_ptr    <= 2'd3;
            push     <= 1'b0;
            data_out <= '0;
            for (int i = 0; i < N_SRC; i++) r_cnt[i] <= '0;
        end else begin
            push <= w_pop;
            if (w_pop) begin
                r_ptr        <= w_idx;
                data_out     <= w_fifo[w_idx];
                r_cnt[w_idx] <= r_cnt[w_idx] + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_arbitro_rr_4a1.sv
// tb_arbitro_rr_4a1: directed bench with a per-cycle reference model of the round-robin merger
module tb_arbitro_rr_4a1;
    logic        clk = 0, reset_L = 1, almost_full = 0, push, idle;
    logic [3:0]  empty = 4'hF, pop;
    logic [11:0] f0 = 0, f1 = 0, f2 = 0, f3 = 0, data_out;
    logic [1:0]  cnt_sel = 0, grant;
    logic [7:0]  cnt_out;
    int errors = 0, checks = 0;

    arbitro_rr_4a1 dut (
        .clk(clk), .reset_L(reset_L), .empty(empty),
        .fifo_out0(f0), .fifo_out1(f1), .fifo_out2(f2), .fifo_out3(f3),
        .almost_full(almost_full), .pop(pop), .push(push), .data_out(data_out),
        .grant(grant), .idle(idle), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: last-granted pointer, word counts, and the word due on push
    int          m_ptr = 3;
    int          m_cnt [4] = '{0, 0, 0, 0};
    bit          m_rst = 1, m_pushed = 0;
    logic [11:0] m_data = 0;

    function automatic int pick();
        if (m_rst || almost_full) return -1;
        for (int k = 1; k <= 4; k++) if (!empty[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [11:0] word(input int s);
        return s == 0 ? f0 : s == 1 ? f1 : s == 2 ? f2 : f3;
    endfunction

    always @(posedge clk or negedge reset_L) begin
        int s;
        if (!reset_L) begin
            m_rst <= 1; m_ptr <= 3; m_pushed <= 0; m_data <= 0;
            m_cnt <= '{0, 0, 0, 0};
        end else begin
            s = pick();
            m_rst    <= 0;
            m_pushed <= s >= 0;
            if (s >= 0) begin
                m_ptr    <= s;
                m_data   <= word(s);
                m_cnt[s] <= (m_cnt[s] + 1) % 256;
            end
        end
    end

    always @(negedge clk) begin
        int s;
        s = pick();
        chk("m_pop", pop, s < 0 ? 0 : 1 << s);
        chk("m_push", push, m_pushed);
        chk("m_data", data_out, m_data);
        chk("m_grant", grant, m_ptr);
        chk("m_idle", idle, !m_rst && !m_pushed);
        chk("m_cnt", cnt_out, m_cnt[cnt_sel]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset_L = 0;
        #1;
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_data", data_out, 12'h000);
        chk("rst_grant", grant, 3);
        chk("rst_idle", idle, 0);
        chk("rst_cnt", cnt_out, 0);
        tick(); tick();
        reset_L = 1;
        tick();
        chk("fsm_idle", idle, 1);
        chk("fsm_push", push, 0);
        // single source
        f2 = 12'h296; empty = 4'b1011;
        #1 chk("one_pop", pop, 4'b0100);
        tick();
        empty = 4'hF;
        #1;
        chk("one_push", push, 1);
        chk("one_data", data_out, 12'h296);
        chk("one_grant", grant, 2);
        chk("fsm_active", idle, 0);
        tick();
        chk("one_push_off", push, 0);
        chk("one_hold", data_out, 12'h296);
        // mid-stream reset with a word in flight
        f0 = 12'hA00; f1 = 12'hB11; f2 = 12'hC22; f3 = 12'hD33; empty = 4'h0; cnt_sel = 2;
        tick();
        chk("pre_rst_push", push, 1);
        reset_L = 0;
        #1;
        chk("mid_rst_pop", pop, 0);
        chk("mid_rst_push", push, 0);
        chk("mid_rst_data", data_out, 12'h000);
        chk("mid_rst_grant", grant, 3);
        chk("mid_rst_cnt", cnt_out, 0);
        tick();
        reset_L = 1;
        tick();
        // fairness
        for (int i = 0; i < 8; i++) begin
            #1 chk("fair_pop", pop, 4'b0001 << (i % 4));
            tick();
        end
        empty = 4'hF;
        chk("fair_data", data_out, 12'hD33);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1 chk("fair_cnt", cnt_out, 2);
        end
        // backpressure
        f1 = 12'h1B1; empty = 4'b1101;
        #1 chk("bp_pop1", pop, 4'b0010);
        tick();
        almost_full = 1; empty = 4'h0;
        #1;
        chk("bp_pop_off", pop, 0);
        chk("bp_push", push, 1);
        chk("bp_data", data_out, 12'h1B1);
        tick();
        chk("bp_push_off", push, 0);
        chk("bp_idle", idle, 1);
        almost_full = 0;
        #1 chk("bp_release", pop, 4'b0100);
        tick();
        empty = 4'hF;
        // counter wrap
        reset_L = 0;
        tick();
        reset_L = 1;
        tick();
        cnt_sel = 1; empty = 4'b1101;
        repeat (255) tick();
        chk("wrap_255", cnt_out, 8'd255);
        tick();
        chk("wrap_256", cnt_out, 8'd0);
        tick();
        chk("wrap_257", cnt_out, 8'd1);
        empty = 4'hF;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
